// File: rtl/period_meter.sv
// Period and high-time meter for a slow asynchronous square wave, counted in clk cycles.
// Optional running min/max of the measured period when PERIOD_MINMAX_EN is defined.
module period_meter #(
  parameter int COUNT_WIDTH = 24,
  parameter int MAX_PERIOD  = 24000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sig_in,
`ifdef PERIOD_MINMAX_EN
  input  logic                 minmax_clr,
  output logic [COUNT_WIDTH:0] min_period,
  output logic [COUNT_WIDTH:0] max_period,
`endif
  output logic [COUNT_WIDTH:0] period,
  output logic [COUNT_WIDTH:0] high_time,
  output logic                 period_valid,
  output logic                 timeout
);

  localparam int W = COUNT_WIDTH + 1;
  localparam logic [W-1:0] MAX_CNT = W'(MAX_PERIOD);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_TIMEOUT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic [W-1:0]           count_q, count_d;
  logic [W-1:0]           period_q, period_d;
  logic [W-1:0]           high_q, high_d;
  logic [W-1:0]           latch_q, latch_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;

  logic         rise, fall, at_max;
  logic [W-1:0] count_inc;

  // Synchronizer chain followed by a one-flop delay for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall      = ~sync_q[SYNC_STAGES-1] & dly_q;
  assign count_inc = count_q + W'(1);
  assign at_max    = (count_inc == MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      period_q  <= '0;
      high_q    <= '0;
      latch_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      high_q    <= high_d;
      latch_q   <= latch_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (rise) state_d = S_MEASURE;
        S_MEASURE: if (!rise && at_max) state_d = S_TIMEOUT;
        S_TIMEOUT: if (rise) state_d = S_MEASURE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // A rise on the terminal count still wins: it is a legal MAX_PERIOD measurement
  always_comb begin
    count_d   = count_q;
    period_d  = period_q;
    high_d    = high_q;
    latch_d   = latch_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!en) begin
      count_d   = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_MEASURE: begin
          if (rise) begin
            period_d = count_inc;
            high_d   = latch_q;
            valid_d  = 1'b1;
            count_d  = '0;
          end else if (at_max) begin
            timeout_d = 1'b1;
            count_d   = '0;
          end else begin
            count_d = count_inc;
          end
          if (fall) latch_d = count_inc;
        end
        S_TIMEOUT: begin
          count_d = '0;
          if (rise) timeout_d = 1'b0;
        end
        default: count_d = '0;
      endcase
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;

`ifdef PERIOD_MINMAX_EN
  logic [W-1:0] min_q, max_q;

  // Tracks the published result, so it trails period_valid by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else if (minmax_clr) begin
      min_q <= '1;
      max_q <= '0;
    end else if (valid_q) begin
      if (period_q < min_q) min_q <= period_q;
      if (period_q > max_q) max_q <= period_q;
    end
  end

  assign min_period = min_q;
  assign max_period = max_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with COUNT_WIDTH=7, MAX_PERIOD=20, SYNC_STAGES=2.
module tb_period_meter;
  localparam int CW   = 7;
  localparam int MAXP = 20;
  localparam int SS   = 2;

  logic        clk = 1'b0;
  logic        rst, en, sig_in;
  logic [CW:0] period, high_time;
  logic        period_valid, timeout;
`ifdef PERIOD_MINMAX_EN
  logic        minmax_clr;
  logic [CW:0] min_period, max_period;
`endif

  int checks = 0, failures = 0, cyc = 0;
  int nvalid, last_p, last_h, gap, last_t, saw_to, got, n;

  period_meter #(.COUNT_WIDTH(CW), .MAX_PERIOD(MAXP), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
`ifdef PERIOD_MINMAX_EN
    .minmax_clr(minmax_clr), .min_period(min_period), .max_period(max_period),
`endif
    .period(period), .high_time(high_time),
    .period_valid(period_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_stats();
    nvalid = 0; last_p = 0; last_h = 0; gap = 0; last_t = cyc; saw_to = 0;
  endtask

  task automatic sample();
    if (period_valid) begin
      nvalid++;
      gap    = cyc - last_t;
      last_t = cyc;
      last_p = int'(period);
      last_h = int'(high_time);
    end
    if (timeout) saw_to = 1;
  endtask

  // n periods of h cycles high then l cycles low, monitoring every cycle
  task automatic wave(input int h, input int l, input int np);
    for (int p = 0; p < np; p++)
      for (int c = 0; c < h + l; c++) begin
        sig_in = (c < h);
        tick();
        sample();
      end
  endtask

  task automatic idle_reset();
    en = 1'b0;
    sig_in = 1'b0;
    repeat (6) tick();
    en = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = 1'b0;
`ifdef PERIOD_MINMAX_EN
    minmax_clr = 1'b0;
`endif
    repeat (3) tick();
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_valid", period_valid, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;

    // Static input: nothing to measure
    en = 1'b1;
    clear_stats();
    repeat (50) begin tick(); sample(); end
    check("static_valid_cnt", nvalid, 0);
    check("static_timeout", saw_to, 0);

    // 4 high / 4 low: four rises, the first only arms
    idle_reset();
    clear_stats();
    wave(4, 4, 4);
    check("w44_valid_cnt", nvalid, 3);
    check("w44_period", last_p, 8);
    check("w44_high", last_h, 4);
    check("w44_gap", gap, 8);
    check("w44_timeout", saw_to, 0);

    // 3 high / 7 low
    idle_reset();
    clear_stats();
    wave(3, 7, 3);
    check("w37_valid_cnt", nvalid, 2);
    check("w37_period", last_p, 10);
    check("w37_high", last_h, 3);
    en = 1'b0;
    tick();
    check("en_off_hold_period", period, 10);
    check("en_off_hold_high", high_time, 3);

    // Timeout 20 cycles after the last strobe
    idle_reset();
    sig_in = 1'b1; repeat (2) tick();
    sig_in = 1'b0; repeat (8) tick();
    sig_in = 1'b1; repeat (2) tick();
    sig_in = 1'b0;
    got = 0;
    for (int i = 0; i < 12 && got == 0; i++) begin
      tick();
      if (period_valid) got = 1;
    end
    check("to_prev_valid", got, 1);
    check("to_prev_period", period, 10);
    check("to_prev_high", high_time, 2);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (timeout) break;
    end
    check("to_latency", n, 20);
    check("to_level", timeout, 1);

    // Rise out of timeout re-arms only; the following rise measures
    clear_stats();
    wave(2, 8, 1);
    check("rearm_valid_cnt", nvalid, 0);
    check("rearm_timeout", timeout, 0);
    clear_stats();
    wave(2, 8, 1);
    check("after_rearm_valid_cnt", nvalid, 1);
    check("after_rearm_period", last_p, 10);
    check("after_rearm_high", last_h, 2);

    // Period of exactly MAX_PERIOD is a valid measurement
    idle_reset();
    clear_stats();
    wave(5, 15, 3);
    check("p20_valid_cnt", nvalid, 2);
    check("p20_period", last_p, 20);
    check("p20_high", last_h, 5);
    check("p20_timeout", saw_to, 0);

    // en dropped mid-period: next rise only re-arms
    idle_reset();
    clear_stats();
    wave(4, 4, 2);
    check("en_pre_valid_cnt", nvalid, 1);
    en = 1'b0;
    tick();
    en = 1'b1;
    check("en_mid_hold_period", period, 8);
    clear_stats();
    wave(4, 4, 2);
    check("en_mid_valid_cnt", nvalid, 1);
    check("en_mid_period", last_p, 8);

    // Asynchronous reset mid-period clears outputs before the next edge
    wave(4, 4, 1);
    sig_in = 1'b1;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_period", period, 0);
    check("rst_mid_high", high_time, 0);
    check("rst_mid_timeout", timeout, 0);
    tick();
    check("rst_mid_valid", period_valid, 0);
    rst = 1'b0;
    sig_in = 1'b0;

`ifdef PERIOD_MINMAX_EN
    idle_reset();
    check("mm_reset_min", min_period, 255);
    check("mm_reset_max", max_period, 0);
    wave(4, 4, 1);
    wave(6, 6, 1);
    wave(5, 5, 1);
    wave(2, 2, 1);
    repeat (4) tick();
    check("mm_min", min_period, 8);
    check("mm_max", max_period, 12);
    minmax_clr = 1'b1;
    tick();
    minmax_clr = 1'b0;
    check("mm_clr_min", min_period, 255);
    check("mm_clr_max", max_period, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
